// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution loop sequencer.
package conv_pkg;

  localparam int unsigned DATAWIDTH_DEF = 5;
  // Internal index arithmetic is one bit wider than the length inputs.
  localparam int unsigned IDXW = DATAWIDTH_DEF + 1;

  typedef logic [DATAWIDTH_DEF-1:0] len_t;
  typedef logic [IDXW-1:0]          idx_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    WRITE,
    DONE
  } conv_state_t;

endpackage

// File: rtl/convolution_loop_bounds.sv
// Inner-loop bounds for one output sample i: first/last signal index
// contributing to y[i], and whether i is the final output sample.
module convolution_loop_bounds
  import conv_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic [DATAWIDTH:0]   i,
  input  logic [DATAWIDTH-1:0] len_x,
  input  logic [DATAWIDTH-1:0] len_h,
  output logic [DATAWIDTH-1:0] jmin,
  output logic [DATAWIDTH-1:0] jmax,
  output logic                 last_i
);

  localparam int unsigned IW = DATAWIDTH + 1;

  logic [IW-1:0] lx_w, lh_w, jmin_w, jmax_w, imax_w;

  // Bounds computed at full index width, then truncated (always fit in DATAWIDTH).
  always_comb begin
    lx_w   = {1'b0, len_x};
    lh_w   = {1'b0, len_h};
    jmin_w = (i >= lh_w) ? (i - lh_w + IW'(1)) : '0;
    jmax_w = (i < lx_w) ? i : (lx_w - IW'(1));
    imax_w = lx_w + lh_w - IW'(2);
    last_i = (i == imax_w);
    jmin   = DATAWIDTH'(jmin_w);
    jmax   = DATAWIDTH'(jmax_w);
  end

endmodule

// File: rtl/convolution_loop_ctrl.sv
// Nested-loop index sequencer for 1-D convolution y[i] = sum_j x[j]*h[i-j].
// Optional build macro CONV_STALL_EN adds the ready_i back-pressure port.
module convolution_loop_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DATAWIDTH-1:0] len_x_i,
  input  logic [DATAWIDTH-1:0] len_h_i,
`ifdef CONV_STALL_EN
  input  logic                 ready_i,
`endif
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [DATAWIDTH:0]   i_o,
  output logic [DATAWIDTH-1:0] j_o,
  output logic [DATAWIDTH-1:0] k_o,
  output logic                 acc_clr_o,
  output logic                 acc_wr_o,
  output logic                 done_o
);

  localparam int unsigned IW = DATAWIDTH + 1;

  conv_state_t          state_q, state_d;
  logic [DATAWIDTH-1:0] lx_q, lx_d, lh_q, lh_d;
  logic [IW-1:0]        i_q, i_d;
  logic [DATAWIDTH-1:0] j_q, j_d, jmin_q, jmin_d, jmax_q, jmax_d;
  // Done pulse for a zero-length start, which never leaves IDLE.
  logic                 zdone_q, zdone_d;

  logic [DATAWIDTH-1:0] b_jmin, b_jmax;
  logic                 b_last;
  logic                 ready;

`ifdef CONV_STALL_EN
  assign ready = ready_i;
`else
  assign ready = 1'b1;
`endif

  convolution_loop_bounds #(
    .DATAWIDTH(DATAWIDTH)
  ) u_bounds (
    .i      (i_q),
    .len_x  (lx_q),
    .len_h  (lh_q),
    .jmin   (b_jmin),
    .jmax   (b_jmax),
    .last_i (b_last)
  );

  // State and loop-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lx_q    <= '0;
      lh_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      jmin_q  <= '0;
      jmax_q  <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lx_q    <= lx_d;
      lh_q    <= lh_d;
      i_q     <= i_d;
      j_q     <= j_d;
      jmin_q  <= jmin_d;
      jmax_q  <= jmax_d;
      zdone_q <= zdone_d;
    end
  end

  // Next-state and loop-counter update.
  always_comb begin
    state_d = state_q;
    lx_d    = lx_q;
    lh_d    = lh_q;
    i_d     = i_q;
    j_d     = j_q;
    jmin_d  = jmin_q;
    jmax_d  = jmax_q;
    zdone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((len_x_i != '0) && (len_h_i != '0)) begin
            lx_d    = len_x_i;
            lh_d    = len_h_i;
            i_d     = '0;
            state_d = INIT;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      INIT: begin
        jmin_d  = b_jmin;
        jmax_d  = b_jmax;
        j_d     = b_jmin;
        state_d = RUN;
      end
      RUN: begin
        if (ready) begin
          if (j_q == jmax_q) begin
            state_d = WRITE;
          end else begin
            j_d = j_q + DATAWIDTH'(1);
          end
        end
      end
      WRITE: begin
        if (b_last) begin
          i_d     = '0;
          j_d     = '0;
          state_d = DONE;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = INIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state and counters.
  always_comb begin
    busy_o    = (state_q != IDLE);
    valid_o   = (state_q == RUN);
    acc_clr_o = (state_q == RUN) && (j_q == jmin_q);
    acc_wr_o  = (state_q == WRITE);
    done_o    = (state_q == DONE) || zdone_q;
    i_o       = i_q;
    j_o       = j_q;
    k_o       = DATAWIDTH'(i_q - {1'b0, j_q});
  end

endmodule
